fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the boot ROM: owns the program counter, drives the ROM's 12-bit `address`, and registers the returned 32-bit word into a fetch register for the decoder. It waits out the ROM's initialisation, supports stall and redirect (jump/branch) from downstream, and recognises the halt opcode to stop fetching.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the boot ROM and registers the returned word.
// Latency: address is combinational from the PC; fetched_* appear one edge after the word is addressed.
// Backpressure: stall holds PC and fetch register; redirect overrides stall and inserts one bubble.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 12,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           BOOT_CYCLES = 2,
  parameter logic [5:0]            HALT_OPCODE = 6'd16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] fetched_instruction,
  output logic [ADDR_WIDTH-1:0] fetched_pc,
  output logic                  fetched_valid,
  output logic                  halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Wide enough to hold BOOT_CYCLES-1 without overflow, and at least one bit.
  localparam int unsigned CNT_W = $clog2(BOOT_CYCLES + 2);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        boot_cnt_q, boot_cnt_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   fetched_instruction_q, fetched_instruction_d;
  logic [ADDR_WIDTH-1:0]   fetched_pc_q, fetched_pc_d;
  logic                    fetched_valid_q, fetched_valid_d;
  logic                    halted_q, halted_d;

  logic                    boot_last;
  logic                    halt_hit;

  // The edge that completes the boot wait; with BOOT_CYCLES=0 this is the very first edge.
  assign boot_last = (32'(boot_cnt_q) + 32'd1) >= BOOT_CYCLES;
  assign halt_hit  = (instruction[DATA_WIDTH-1 -: 6] == HALT_OPCODE);

  assign address             = pc_q;
  assign fetched_instruction = fetched_instruction_q;
  assign fetched_pc          = fetched_pc_q;
  assign fetched_valid       = fetched_valid_q;
  assign halted              = halted_q;

  // Next-state and datapath: redirect beats stall in RUN; stall is meaningless outside RUN.
  always_comb begin
    state_d               = state_q;
    boot_cnt_d            = boot_cnt_q;
    pc_d                  = pc_q;
    fetched_instruction_d = fetched_instruction_q;
    fetched_pc_d          = fetched_pc_q;
    fetched_valid_d       = fetched_valid_q;
    halted_d              = halted_q;

    unique case (state_q)
      ST_BOOT: begin
        pc_d            = RESET_PC;
        fetched_valid_d = 1'b0;
        halted_d        = 1'b0;
        if (boot_last) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        halted_d = 1'b0;
        if (redirect) begin
          pc_d            = redirect_target;
          fetched_valid_d = 1'b0;
        end else if (!stall) begin
          fetched_instruction_d = instruction;
          fetched_pc_d          = pc_q;
          fetched_valid_d       = 1'b1;
          pc_d                  = pc_q + ADDR_WIDTH'(1);
          // The halt word itself is delivered; HALT takes effect from the next edge.
          if (halt_hit) begin
            state_d = ST_HALT;
          end
        end
      end

      ST_HALT: begin
        fetched_valid_d = 1'b0;
        if (redirect) begin
          pc_d = redirect_target;
        end
        if (resume) begin
          state_d  = ST_RUN;
          halted_d = 1'b0;
        end else begin
          halted_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State registers; reset restarts the boot wait from scratch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q               <= ST_BOOT;
      boot_cnt_q            <= '0;
      pc_q                  <= RESET_PC;
      fetched_instruction_q <= '0;
      fetched_pc_q          <= '0;
      fetched_valid_q       <= 1'b0;
      halted_q              <= 1'b0;
    end else begin
      state_q               <= state_d;
      boot_cnt_q            <= boot_cnt_d;
      pc_q                  <= pc_d;
      fetched_instruction_q <= fetched_instruction_d;
      fetched_pc_q          <= fetched_pc_d;
      fetched_valid_q       <= fetched_valid_d;
      halted_q              <= halted_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int BOOT = 2;
  localparam logic [31:0] HALT_W = {6'd16, 26'd0};

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [11:0] redirect_target;
  logic        resume;
  logic [11:0] address;
  logic [31:0] instruction;
  logic [31:0] fetched_instruction;
  logic [11:0] fetched_pc;
  logic        fetched_valid;
  logic        halted;

  logic [31:0] rom [4096];

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clock               (clock),
    .reset               (reset),
    .stall               (stall),
    .redirect            (redirect),
    .redirect_target     (redirect_target),
    .resume              (resume),
    .address             (address),
    .instruction         (instruction),
    .fetched_instruction (fetched_instruction),
    .fetched_pc          (fetched_pc),
    .fetched_valid       (fetched_valid),
    .halted              (halted)
  );

  assign instruction = rom[address];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Deterministic ROM image for the directed part: address in the low bits, halt word at 137.
  function automatic logic [31:0] word_of(input int a);
    logic [11:0] a12;
    a12 = 12'(a);
    if (a == 137) return HALT_W;
    return {6'd1, 14'd0, a12};
  endfunction

  typedef struct {
    logic        st;
    logic        rd;
    logic [11:0] tg;
    logic        rs;
    logic        ev;
    logic [11:0] efpc;
    logic [11:0] eaddr;
    logic        eh;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, input logic rd, input int tg, input logic rs,
                     input logic ev, input int efpc, input int eaddr, input logic eh);
    vec_t v;
    v.st = st; v.rd = rd; v.tg = 12'(tg); v.rs = rs;
    v.ev = ev; v.efpc = 12'(efpc); v.eaddr = 12'(eaddr); v.eh = eh;
    vq.push_back(v);
  endtask

  // Behavioural reference: mode 0 = boot wait, 1 = fetching, 2 = halted.
  int          m_mode;
  int          m_boot;
  int          m_pc;
  logic [31:0] m_fi;
  int          m_fpc;
  logic        m_fv;
  logic        m_halted;

  task automatic model_reset();
    m_mode = 0; m_boot = 0; m_pc = 0; m_fi = '0; m_fpc = 0; m_fv = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [11:0] tg, input logic rs);
    if (m_mode == 0) begin
      m_boot = m_boot + 1;
      if (m_boot >= BOOT) m_mode = 1;
    end else if (m_mode == 1) begin
      if (rd) begin
        m_pc = int'(tg);
        m_fv = 1'b0;
      end else if (!st) begin
        m_fi  = rom[m_pc];
        m_fpc = m_pc;
        m_fv  = 1'b1;
        m_pc  = (m_pc + 1) % 4096;
        if (m_fi[31:26] == 6'd16) m_mode = 2;
      end
    end else begin
      m_fv = 1'b0;
      m_halted = 1'b1;
      if (rd) m_pc = int'(tg);
      if (rs) begin
        m_mode = 1;
        m_halted = 1'b0;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(address), 32'd0);
    chk({tag, "_valid"}, 32'(fetched_valid), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_finstr"}, fetched_instruction, 32'd0);
    chk({tag, "_fpc"}, 32'(fetched_pc), 32'd0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0; resume = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = word_of(i);

    // Reset state.
    #2;
    check_reset_vals("reset");
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;

    // Directed table from reset release.
    add(0,0,0,0,   0,0,0,0);      // boot edge 1
    add(0,0,0,0,   0,0,0,0);      // boot edge 2
    add(0,0,0,0,   1,0,1,0);
    add(0,0,0,0,   1,1,2,0);
    add(0,0,0,0,   1,2,3,0);
    add(0,0,0,0,   1,3,4,0);
    add(0,0,0,0,   1,4,5,0);
    add(1,0,0,0,   1,4,5,0);      // stall x3 at pc=5
    add(1,0,0,0,   1,4,5,0);
    add(1,0,0,0,   1,4,5,0);
    add(0,0,0,0,   1,5,6,0);
    add(1,1,94,0,  0,5,94,0);     // redirect wins over stall
    add(0,0,0,0,   1,94,95,0);
    add(0,1,137,0, 0,94,137,0);
    add(0,0,0,0,   1,137,138,0);  // halt word delivered
    add(0,0,0,0,   0,137,138,1);
    add(0,0,0,0,   0,137,138,1);
    add(1,0,0,0,   0,137,138,1);  // stall ignored in HALT
    add(0,0,0,1,   0,137,138,0);  // resume edge
    add(0,0,0,0,   1,138,139,0);
    add(0,1,4095,0,0,138,4095,0);
    add(0,0,0,0,   1,4095,0,0);   // wrap
    add(0,0,0,0,   1,0,1,0);
    add(0,1,137,0, 0,0,137,0);
    add(1,0,0,0,   0,0,137,0);    // halt word under stall: ignored
    add(1,1,10,0,  0,0,10,0);     // halt word under redirect: ignored
    add(0,0,0,1,   1,10,11,0);    // resume in RUN has no effect

    for (int i = 0; i < vq.size(); i++) begin
      stall = vq[i].st; redirect = vq[i].rd; redirect_target = vq[i].tg; resume = vq[i].rs;
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(fetched_valid), 32'(vq[i].ev));
      chk($sformatf("tbl%0d_fpc", i), 32'(fetched_pc), 32'(vq[i].efpc));
      chk($sformatf("tbl%0d_addr", i), 32'(address), 32'(vq[i].eaddr));
      chk($sformatf("tbl%0d_halted", i), 32'(halted), 32'(vq[i].eh));
      if (vq[i].ev)
        chk($sformatf("tbl%0d_finstr", i), fetched_instruction, word_of(int'(vq[i].efpc)));
    end
    stall = 1'b0; redirect = 1'b0; resume = 1'b0;

    // Asynchronous reset between edges, then the boot wait repeats.
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check_reset_vals("async");
    #2 reset = 1'b1;
    for (int e = 0; e < BOOT; e++) begin
      @(posedge clock);
      #1;
      chk($sformatf("reboot%0d_valid", e), 32'(fetched_valid), 32'd0);
      chk($sformatf("reboot%0d_addr", e), 32'(address), 32'd0);
    end
    @(posedge clock);
    #1;
    chk("reboot_first_valid", 32'(fetched_valid), 32'd1);
    chk("reboot_first_fpc", 32'(fetched_pc), 32'd0);
    chk("reboot_first_finstr", fetched_instruction, word_of(0));

    // Randomized run against the reference model with a random ROM image.
    reset = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      rom[i] = $urandom;
      if ($urandom_range(0, 9) == 0) rom[i][31:26] = 6'd16;
      else if (rom[i][31:26] == 6'd16) rom[i][31:26] = 6'd17;
    end
    model_reset();
    #2 reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      stall           = ($urandom_range(0, 3) == 0);
      redirect        = ($urandom_range(0, 9) == 0);
      redirect_target = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
      resume          = ($urandom_range(0, 2) == 0);
      model_step(stall, redirect, redirect_target, resume);
      @(posedge clock);
      #1;
      chk($sformatf("rnd%0d_addr", c), 32'(address), 32'(m_pc));
      chk($sformatf("rnd%0d_valid", c), 32'(fetched_valid), 32'(m_fv));
      chk($sformatf("rnd%0d_halted", c), 32'(halted), 32'(m_halted));
      if (m_fv) begin
        chk($sformatf("rnd%0d_fpc", c), 32'(fetched_pc), 32'(m_fpc));
        chk($sformatf("rnd%0d_finstr", c), fetched_instruction, m_fi);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
